// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if
//   Bundles the decode/execute control seen by the hazard scoreboard.
//   master : pipeline control (drives the ID instruction and the EX redirect)
//   slave  : hazard_scoreboard (drives stall, flush, forwarding selects, counter)
//   Signals:
//     id_valid, id_src, id_src_used, id_wr, id_dst, id_is_load : ID instruction
//     ex_redirect : taken branch/jump resolved in EX
//     stall, flush, fwd_sel, stall_cnt : hazard unit results
//     id_wb_bypass : only with HAZARD_SCOREBOARD_WB_BYPASS_EN defined
//
// Handshake: id_valid marks ID as holding a real instruction; the instruction
// is accepted into EX on a rising edge where id_valid=1, stall=0 and flush=0.
// stall is the back-pressure: while it is high the master must hold the same
// ID instruction. flush overrides stall and discards the ID instruction.
interface hazard_scoreboard_if #(
    parameter int RADDR_W = 5,
    parameter int NSRC    = 2,
    parameter int DEPTH   = 3,
    parameter int CNT_W   = 16
);
    localparam int FW = $clog2(DEPTH);

    logic                    id_valid;
    logic [NSRC*RADDR_W-1:0] id_src;
    logic [NSRC-1:0]         id_src_used;
    logic                    id_wr;
    logic [RADDR_W-1:0]      id_dst;
    logic                    id_is_load;
    logic                    ex_redirect;
    logic                    stall;
    logic                    flush;
    logic [NSRC*FW-1:0]      fwd_sel;
    logic [CNT_W-1:0]        stall_cnt;
`ifdef HAZARD_SCOREBOARD_WB_BYPASS_EN
    logic [NSRC-1:0]         id_wb_bypass;

    modport master (
        output id_valid, id_src, id_src_used, id_wr, id_dst, id_is_load, ex_redirect,
        input  stall, flush, fwd_sel, stall_cnt, id_wb_bypass
    );
    modport slave (
        input  id_valid, id_src, id_src_used, id_wr, id_dst, id_is_load, ex_redirect,
        output stall, flush, fwd_sel, stall_cnt, id_wb_bypass
    );
`else
    modport master (
        output id_valid, id_src, id_src_used, id_wr, id_dst, id_is_load, ex_redirect,
        input  stall, flush, fwd_sel, stall_cnt
    );
    modport slave (
        input  id_valid, id_src, id_src_used, id_wr, id_dst, id_is_load, ex_redirect,
        output stall, flush, fwd_sel, stall_cnt
    );
`endif
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Tracks in-flight register writes from EX (slot 0) to WB (slot DEPTH-1)
//   and produces operand forwarding selects for EX, the load-use / WB-collision
//   stall for ID, and the front-end flush on an EX redirect.
//   Ports:
//     clk     : clock, rising edge
//     reset_n : asynchronous active-low reset
//     bus     : hazard_scoreboard_if.slave (ID instruction, redirect, results)
//   Optional feature macro: HAZARD_SCOREBOARD_WB_BYPASS_EN
//     defined   : id_wb_bypass flags ID operands matching the WB slot, and the
//                 WB collision no longer stalls (decode takes WB data instead)
//     undefined : a WB collision stalls ID for one cycle
//   No FSM: the only state is the slot shift register and the stall counter.
module hazard_scoreboard #(
    parameter int RADDR_W  = 5,
    parameter int DEPTH    = 3,
    parameter int NSRC     = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    hazard_scoreboard_if.slave bus
);
    localparam int FW = $clog2(DEPTH);

    // Slot state; slot 0 also keeps its source operands for forwarding.
    logic [DEPTH-1:0]        slot_valid;
    logic [DEPTH-1:0]        slot_wr;
    logic [DEPTH-1:0]        slot_load;
    logic [RADDR_W-1:0]      slot_dst [DEPTH];
    logic [NSRC*RADDR_W-1:0] ex_src;
    logic [NSRC-1:0]         ex_used;
    logic [CNT_W-1:0]        stall_cnt_q;

    logic                    load_hit;
    logic [NSRC-1:0]         wb_hit;
    logic                    stall_c;
    logic                    issue;
    logic [NSRC*FW-1:0]      fwd_c;

    // ID-side hazard detection against every tracked slot.
    always_comb begin : id_hazard
        logic [RADDR_W-1:0] src_k;
        logic               hit;
        load_hit = 1'b0;
        wb_hit   = '0;
        src_k    = '0;
        hit      = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            src_k = bus.id_src[k*RADDR_W +: RADDR_W];
            for (int j = 0; j < DEPTH; j++) begin
                hit = bus.id_src_used[k] && slot_valid[j] && slot_wr[j] &&
                      (slot_dst[j] == src_k) && (src_k != '0);
                if ((j < LOAD_LAT) && slot_load[j] && hit) begin
                    load_hit = 1'b1;
                end
                if ((j == DEPTH-1) && hit) begin
                    wb_hit[k] = 1'b1;
                end
            end
        end
    end

    // A redirect kills the ID instruction, so it can never be stalled.
    always_comb begin
`ifdef HAZARD_SCOREBOARD_WB_BYPASS_EN
        stall_c = bus.id_valid && !bus.ex_redirect && load_hit;
`else
        stall_c = bus.id_valid && !bus.ex_redirect && (load_hit || (|wb_hit));
`endif
        issue = bus.id_valid && !stall_c && !bus.ex_redirect;
    end

    // EX forwarding: scan oldest to youngest so the youngest producer
    // (smallest slot index) is the last assignment and wins.
    always_comb begin : ex_forward
        logic [RADDR_W-1:0] src_k;
        fwd_c = '0;
        src_k = '0;
        for (int k = 0; k < NSRC; k++) begin
            src_k = ex_src[k*RADDR_W +: RADDR_W];
            for (int i = DEPTH-1; i >= 1; i--) begin
                if (slot_valid[0] && ex_used[k] && slot_valid[i] && slot_wr[i] &&
                    (slot_dst[i] == src_k) && (src_k != '0)) begin
                    fwd_c[k*FW +: FW] = FW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_valid  <= '0;
            slot_wr     <= '0;
            slot_load   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_dst[i] <= '0;
            end
            ex_src      <= '0;
            ex_used     <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int i = DEPTH-1; i > 0; i--) begin
                slot_valid[i] <= slot_valid[i-1];
                slot_wr[i]    <= slot_wr[i-1];
                slot_load[i]  <= slot_load[i-1];
                slot_dst[i]   <= slot_dst[i-1];
            end
            // Fields are loaded regardless; a bubble is marked by valid=0 alone.
            slot_valid[0] <= issue;
            slot_wr[0]    <= bus.id_wr;
            slot_load[0]  <= bus.id_is_load;
            slot_dst[0]   <= bus.id_dst;
            ex_src        <= bus.id_src;
            ex_used       <= bus.id_src_used;
            if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign bus.stall     = stall_c;
    assign bus.flush     = bus.ex_redirect;
    assign bus.fwd_sel   = fwd_c;
    assign bus.stall_cnt = stall_cnt_q;
`ifdef HAZARD_SCOREBOARD_WB_BYPASS_EN
    assign bus.id_wb_bypass = wb_hit;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
    localparam int DEPTH    = 3;
    localparam int LOAD_LAT = 1;
`ifdef HAZARD_SCOREBOARD_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic       v;
        logic [4:0] s0;
        logic [4:0] s1;
        logic [1:0] used;
        logic       wr;
        logic [4:0] dst;
        logic       ld;
        logic       rd;
        logic       e_stall;
        logic [1:0] e_f0;
        logic [1:0] e_f1;
        logic [1:0] e_byp;
    } vec_t;

    typedef struct {
        logic       wr;
        logic       ld;
        logic [4:0] dst;
        logic [4:0] s0;
        logic [4:0] s1;
        logic [1:0] used;
        int         age;
    } flight_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    flight_t pipe[$];
    logic [15:0] exp_cnt;

    hazard_scoreboard_if #(.RADDR_W(5), .NSRC(2), .DEPTH(DEPTH), .CNT_W(16)) hif ();

    hazard_scoreboard #(
        .RADDR_W(5), .DEPTH(DEPTH), .NSRC(2), .LOAD_LAT(LOAD_LAT), .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(hif.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] used, input logic wr, input logic [4:0] dst,
                         input logic ld, input logic rd);
        hif.id_valid    = v;
        hif.id_src      = {s1, s0};
        hif.id_src_used = used;
        hif.id_wr       = wr;
        hif.id_dst      = dst;
        hif.id_is_load  = ld;
        hif.ex_redirect = rd;
    endtask

    function automatic vec_t mk(logic v, logic [4:0] s0, logic [4:0] s1, logic [1:0] used,
                                logic wr, logic [4:0] dst, logic ld, logic rd,
                                logic st, logic [1:0] f0, logic [1:0] f1, logic [1:0] byp);
        vec_t r;
        r.v = v; r.s0 = s0; r.s1 = s1; r.used = used; r.wr = wr; r.dst = dst;
        r.ld = ld; r.rd = rd; r.e_stall = st; r.e_f0 = f0; r.e_f1 = f1; r.e_byp = byp;
        return r;
    endfunction

    // Reference model: instructions in flight, each tagged with its age in
    // cycles since entering EX (age 0 = EX, age DEPTH-1 = WB).
    task automatic model_eval(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                              input logic [1:0] used, input logic rd,
                              output logic e_stall, output logic [1:0] e_f0,
                              output logic [1:0] e_f1, output logic [1:0] e_byp);
        logic       load_hz;
        logic [4:0] sr;
        int         best;
        e_f0 = 2'd0; e_f1 = 2'd0; e_byp = 2'b00; load_hz = 1'b0;
        foreach (pipe[a]) begin
            if (pipe[a].age == 0) begin
                for (int k = 0; k < 2; k++) begin
                    sr = (k == 0) ? pipe[a].s0 : pipe[a].s1;
                    best = DEPTH;
                    if (pipe[a].used[k] && sr != 5'd0) begin
                        foreach (pipe[b]) begin
                            if (pipe[b].age >= 1 && pipe[b].wr && pipe[b].dst == sr &&
                                pipe[b].age < best) best = pipe[b].age;
                        end
                    end
                    if (best < DEPTH) begin
                        if (k == 0) e_f0 = 2'(best); else e_f1 = 2'(best);
                    end
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            sr = (k == 0) ? s0 : s1;
            if (used[k] && sr != 5'd0) begin
                foreach (pipe[b]) begin
                    if (pipe[b].wr && pipe[b].dst == sr) begin
                        if (pipe[b].ld && pipe[b].age < LOAD_LAT) load_hz = 1'b1;
                        if (pipe[b].age == DEPTH-1) e_byp[k] = 1'b1;
                    end
                end
            end
        end
        e_stall = v && !rd && (load_hz || (!BYPASS && (e_byp != 2'b00)));
    endtask

    task automatic model_advance(input logic issue, input logic wr, input logic ld,
                                 input logic [4:0] dst, input logic [4:0] s0,
                                 input logic [4:0] s1, input logic [1:0] used);
        flight_t f;
        foreach (pipe[a]) pipe[a].age++;
        for (int a = pipe.size() - 1; a >= 0; a--) begin
            if (pipe[a].age >= DEPTH) pipe.delete(a);
        end
        if (issue) begin
            f.wr = wr; f.ld = ld; f.dst = dst; f.s0 = s0; f.s1 = s1; f.used = used; f.age = 0;
            pipe.push_back(f);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);
        pipe.delete();
        exp_cnt = 16'd0;
        @(negedge clk);
        #2 reset_n = 1'b1;
    endtask

    // One cycle of hand sequence: drive after the edge, sample at negedge.
    task automatic step(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] used, input logic wr, input logic [4:0] dst,
                        input logic ld);
        @(posedge clk);
        #1 drive(v, s0, s1, used, wr, dst, ld, 1'b0);
        @(negedge clk);
    endtask

    vec_t tbl[15];

    initial begin
        logic       e_stall;
        logic [1:0] e_f0, e_f1, e_byp;
        logic       v, wr, ld, rd;
        logic [4:0] s0, s1, dst;
        logic [1:0] used;

        checks = 0;
        failures = 0;
        exp_cnt = 16'd0;
        reset_n = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);

        // v  s0  s1 used wr dst ld rd | stall f0 f1 byp
        tbl[0]  = mk(1, 1, 2, 2'b11, 1, 3, 0, 0,  0, 0, 0, 2'b00);
        tbl[1]  = mk(1, 3, 1, 2'b11, 1, 4, 0, 0,  0, 0, 0, 2'b00);
        tbl[2]  = mk(1, 3, 0, 2'b11, 1, 5, 0, 0,  0, 1, 0, 2'b00);
        tbl[3]  = mk(1, 3, 1, 2'b11, 1, 7, 0, 0,  !BYPASS, 2, 0, 2'b01);
        tbl[4]  = mk(1, 3, 1, 2'b11, 1, 7, 0, 0,  0, 0, 0, 2'b00);
        tbl[5]  = mk(1, 1, 0, 2'b01, 1, 5, 1, 0,  0, 0, 0, 2'b00);
        tbl[6]  = mk(1, 5, 2, 2'b11, 1, 6, 0, 0,  1, 0, 0, 2'b00);
        tbl[7]  = mk(1, 5, 2, 2'b11, 1, 6, 0, 0,  0, 0, 0, 2'b00);
        tbl[8]  = mk(1, 0, 0, 2'b11, 1, 0, 0, 0,  0, 2, 0, 2'b00);
        tbl[9]  = mk(1, 0, 0, 2'b11, 1, 9, 0, 0,  0, 0, 0, 2'b00);
        tbl[10] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0,  0, 0, 0, 2'b00);
        tbl[11] = mk(1, 1, 0, 2'b01, 1, 10, 1, 0, 0, 0, 0, 2'b00);
        tbl[12] = mk(1, 10, 10, 2'b11, 1, 11, 0, 1, 0, 0, 0, 2'b00);
        tbl[13] = mk(1, 10, 10, 2'b11, 1, 11, 0, 0, 0, 0, 0, 2'b00);
        tbl[14] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0,  0, 2, 2, 2'b00);

        // reset state
        #12;
        check("reset stall", 32'(hif.stall), 32'd0);
        check("reset fwd_sel", 32'(hif.fwd_sel), 32'd0);
        check("reset stall_cnt", 32'(hif.stall_cnt), 32'd0);
        check("reset flush", 32'(hif.flush), 32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;

        // directed table
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1 drive(tbl[i].v, tbl[i].s0, tbl[i].s1, tbl[i].used, tbl[i].wr,
                     tbl[i].dst, tbl[i].ld, tbl[i].rd);
            @(negedge clk);
            check($sformatf("row%0d stall", i), 32'(hif.stall), 32'(tbl[i].e_stall));
            check($sformatf("row%0d flush", i), 32'(hif.flush), 32'(tbl[i].rd));
            check($sformatf("row%0d fwd0", i), 32'(hif.fwd_sel[1:0]), 32'(tbl[i].e_f0));
            check($sformatf("row%0d fwd1", i), 32'(hif.fwd_sel[3:2]), 32'(tbl[i].e_f1));
`ifdef HAZARD_SCOREBOARD_WB_BYPASS_EN
            check($sformatf("row%0d bypass", i), 32'(hif.id_wb_bypass), 32'(tbl[i].e_byp));
`endif
        end
        check("table stall_cnt", 32'(hif.stall_cnt), BYPASS ? 32'd1 : 32'd2);

        // randomized stimulus against the reference model
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk);
            v    = ($urandom_range(0, 3) != 0);
            s0   = 5'($urandom_range(0, 3));
            s1   = 5'($urandom_range(0, 3));
            used = 2'($urandom_range(0, 3));
            ld   = ($urandom_range(0, 3) == 0);
            wr   = ld || ($urandom_range(0, 3) != 0);
            dst  = 5'($urandom_range(0, 3));
            rd   = ($urandom_range(0, 9) == 0);
            #1 drive(v, s0, s1, used, wr, dst, ld, rd);
            model_eval(v, s0, s1, used, rd, e_stall, e_f0, e_f1, e_byp);
            @(negedge clk);
            check("rand stall", 32'(hif.stall), 32'(e_stall));
            check("rand flush", 32'(hif.flush), 32'(rd));
            check("rand fwd0", 32'(hif.fwd_sel[1:0]), 32'(e_f0));
            check("rand fwd1", 32'(hif.fwd_sel[3:2]), 32'(e_f1));
            check("rand stall_cnt", 32'(hif.stall_cnt), 32'(exp_cnt));
`ifdef HAZARD_SCOREBOARD_WB_BYPASS_EN
            check("rand bypass", 32'(hif.id_wb_bypass), 32'(e_byp));
`endif
            if (e_stall && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            model_advance(v && !e_stall && !rd, wr, ld, dst, s0, s1, used);
        end

        // asynchronous reset in the middle of a load-use stall
        do_reset();
        step(1, 5'd2, 5'd3, 2'b11, 1, 5'd1, 0);   // add r1
        step(1, 5'd1, 5'd0, 2'b01, 1, 5'd5, 1);   // lw r5 <- r1
        step(1, 5'd5, 5'd0, 2'b01, 1, 5'd6, 0);   // add r6 <- r5
        check("midstall stall", 32'(hif.stall), 32'd1);
        check("midstall fwd0", 32'(hif.fwd_sel[1:0]), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("async reset stall", 32'(hif.stall), 32'd0);
        check("async reset fwd_sel", 32'(hif.fwd_sel), 32'd0);
        check("async reset stall_cnt", 32'(hif.stall_cnt), 32'd0);
        hif.ex_redirect = 1'b1;
        #1 check("flush in reset", 32'(hif.flush), 32'd1);
        hif.ex_redirect = 1'b0;
        #1 check("flush in reset low", 32'(hif.flush), 32'd0);
        reset_n = 1'b1;
        #1 check("first after reset stall", 32'(hif.stall), 32'd0);
        @(negedge clk);
        check("first after reset fwd", 32'(hif.fwd_sel), 32'd0);
        check("first after reset cnt", 32'(hif.stall_cnt), 32'd0);

        // stall counter saturation
        do_reset();
        step(1, 5'd1, 5'd0, 2'b01, 1, 5'd5, 1);   // lw r5
        force dut.stall_cnt_q = 16'hFFFE;
        #1 release dut.stall_cnt_q;
        step(1, 5'd5, 5'd0, 2'b01, 1, 5'd6, 0);   // dependent: stalls
        check("sat stall a", 32'(hif.stall), 32'd1);
        check("sat cnt pre", 32'(hif.stall_cnt), 32'hFFFE);
        step(1, 5'd5, 5'd0, 2'b01, 1, 5'd6, 0);   // bubble ahead, issues
        check("sat stall b", 32'(hif.stall), 32'd0);
        check("sat cnt reach", 32'(hif.stall_cnt), 32'hFFFF);
        step(1, 5'd1, 5'd0, 2'b01, 1, 5'd5, 1);   // lw r5 again
        step(1, 5'd5, 5'd0, 2'b01, 1, 5'd7, 0);   // dependent: stalls
        check("sat stall c", 32'(hif.stall), 32'd1);
        step(1, 5'd5, 5'd0, 2'b01, 1, 5'd7, 0);
        check("sat cnt hold", 32'(hif.stall_cnt), 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard unit for the in-order pipelined core; successor to the current fixed forwarding unit.
- Tracks in-flight register writes from EX through WB in a DEPTH-slot shift register.
- Outputs per-operand forwarding selects for the EX instruction, load-use stall for ID, and front-end flush on EX redirect.
- Sits beside the ID/EX pipeline register, driven from decode and execute control.

Parameters:
RADDR_W, 5, register address width; register 0 is hardwired zero.
DEPTH, 3, tracked stages; slot 0 = EX, slot DEPTH-1 = WB, minimum 2.
NSRC, 2, source operands per instruction.
LOAD_LAT, 1, cycles a load result stays unforwardable after leaving EX; range 1..DEPTH-2.
FW, $clog2(DEPTH), forwarding select width.
CNT_W, 16, stall counter width.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_src  in  NSRC*RADDR_W  ID source register numbers, operand k at [k*RADDR_W +: RADDR_W]
id_src_used  in  NSRC  operand k actually read
id_wr  in  1  ID instruction writes a register
id_dst  in  RADDR_W  ID destination, after RegDst selection
id_is_load  in  1  ID instruction is a load
ex_redirect  in  1  taken branch/jump resolved in EX this cycle
stall  out  1  hold PC and IF/ID; insert bubble into ID/EX
flush  out  1  kill IF/ID and ID contents
fwd_sel  out  NSRC*FW  per EX operand: 0 = regfile/ID/EX value, i = forward from slot i
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Slot fields: valid, wr, dst, is_load, and src/used for slot 0 only.
- Every cycle, slot i+1 <= slot i.
- Slot 0 <= ID instruction when id_valid && !stall && !flush; otherwise slot 0 gets a bubble (valid=0).
- A slot matches register r when valid && wr && dst==r && r!=0. Register 0 never matches.
- fwd_sel[k] (combinational, from slot 0 sources):
  - Zero if slot 0 is invalid or its used[k]=0.
  - Otherwise the smallest i in 1..DEPTH-1 whose slot matches src[k]; zero if none.
  - Youngest producer wins.
- Load-use stall: asserted when id_valid && !ex_redirect and any used ID source matches a slot j in 0..LOAD_LAT-1 with is_load=1.
- WB stall: without the optional feature, stall is also asserted when a used ID source matches slot DEPTH-1 (regfile write/read collision).
- Stall is combinational and lasts until the hazard clears. With DEPTH=3, LOAD_LAT=1, a dependent instruction after a load stalls exactly 1 cycle.
- flush = ex_redirect, combinational.
- Redirect and stall in the same cycle: redirect wins, stall=0, slot 0 gets a bubble. The EX instruction itself is not killed and shifts to slot 1 normally.
- stall_cnt increments on each cycle stall=1 and saturates at all-ones.
- Reset (asynchronous, reset_n low):
  - All slots become invalid; stall=0, flush follows its input, fwd_sel=0, stall_cnt=0.
  - Reset mid-stall drops the stall immediately.
  - On release, the first ID instruction issues without hazard.

Optional Feature:
- Macro: HAZARD_SCOREBOARD_WB_BYPASS_EN.
- Defined:
  - Adds output id_wb_bypass (NSRC bits); bit k=1 when used ID source k matches slot DEPTH-1.
  - The decode mux takes the WB write data instead of the regfile read.
  - No WB-collision stall is generated.
- Undefined: port absent; the WB collision produces a 1-cycle stall as above.

Test Plan:
- Back-to-back ALU chain, DEPTH=3: add r3 writes, then add r4 reads r3 -> fwd_sel operand 0 = 1 with consumer in EX. Instruction after that reading r3 -> fwd_sel = 2. stall stays 0.
- Load-use, DEPTH=3, LOAD_LAT=1: lw r5 then add r6 reading r5 -> stall=1 for exactly 1 cycle, bubble in slot 0, then fwd_sel = 2, stall_cnt = 1.
- Writes to r0: producer dst=0 followed by consumer of r0 -> fwd_sel = 0, no stall.
- Redirect during load-use stall: ex_redirect=1 while a load-use hazard exists -> flush=1, stall=0, slot 0 becomes a bubble next cycle.
- WB collision: consumer in ID while producer in slot 2 -> with macro, id_wb_bypass=1 and stall=0; without macro, stall=1 for 1 cycle.
- Asynchronous reset asserted mid-stall: stall, fwd_sel and stall_cnt go to 0 immediately. Force stall_cnt to 0xFFFF; a further stall holds it at 0xFFFF.
